// File: rtl/mem_copy_master.sv
// Word-by-word memory copy engine: reads one 32-bit word from the source pointer,
// writes it to the destination pointer, and repeats until the word count is exhausted.
module mem_copy_master #(
    parameter int LEN_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LEN_WIDTH-1:0] words_done,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          address,
    output logic [31:0]          data_to_mem,
    input  logic [31:0]          data_from_mem,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [31:0]          src_ptr;
    logic [31:0]          dst_ptr;
    logic [31:0]          buffer;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 start_accept;
    logic                 misaligned;

    assign start_accept = (state == IDLE) && start;
    assign misaligned   = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
    assign fsm_state    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus outputs decode from the registered state only, so reset drops strobes at once.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        address     = 32'h0;
        data_to_mem = 32'h0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (misaligned || (len == '0)) begin
                        state_next = DONE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                busy       = 1'b1;
                mem_read   = 1'b1;
                address    = src_ptr;
                state_next = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_write   = 1'b1;
                address     = dst_ptr;
                data_to_mem = buffer;
                // remaining still holds the pre-decrement count here.
                state_next  = (remaining == LEN_WIDTH'(1)) ? DONE : READ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr    <= 32'h0;
            dst_ptr    <= 32'h0;
            buffer     <= 32'h0;
            remaining  <= '0;
            words_done <= '0;
            error      <= 1'b0;
        end else begin
            if (start_accept) begin
                src_ptr    <= src_addr;
                dst_ptr    <= dst_addr;
                remaining  <= len;
                words_done <= '0;
                error      <= misaligned;
            end
            if (state == READ) begin
                buffer <= data_from_mem;
            end
            if (state == WRITE) begin
                src_ptr    <= src_ptr + 32'd4;
                dst_ptr    <= dst_ptr + 32'd4;
                remaining  <= remaining - LEN_WIDTH'(1);
                words_done <= words_done + LEN_WIDTH'(1);
            end
        end
    end

endmodule
